// File: rtl/issue_pkg.sv
// Shared issue-queue parameters and the wrap-aware age comparison used by
// the issue queue, the wakeup logic and the select arbiter.
package issue_pkg;

  localparam int CIQ_DEPTH = 16;
  localparam int ISSUE_NUM = 4;
  localparam int AGE       = 5;
  localparam int IQ_IDX_W  = 4;

  // Ages stay within half the tag range of each other, so the MSB of the
  // modular difference orders them exactly across wrap-around.
  function automatic logic age_older(
    input logic [AGE-1:0]      a,
    input logic [AGE-1:0]      b,
    input logic [IQ_IDX_W-1:0] ia,
    input logic [IQ_IDX_W-1:0] ib
  );
    logic [AGE-1:0] diff;
    diff = a - b;
    if (diff == '0) begin
      return ia < ib;
    end
    return diff[AGE-1];
  endfunction

endpackage

// File: rtl/issue_select_oldest_pick.sv
// Combinational oldest-entry picker: returns the oldest eligible entry as
// one-hot, index and valid.
module oldest_pick
  import issue_pkg::*;
(
  input  logic [CIQ_DEPTH-1:0]          elig,
  input  logic [CIQ_DEPTH-1:0][AGE-1:0] ages,
  output logic [CIQ_DEPTH-1:0]          pick_onehot,
  output logic [IQ_IDX_W-1:0]           pick_idx,
  output logic                          pick_valid
);

  logic [IQ_IDX_W-1:0] best_idx;
  logic                found;

  // Ascending scan: an equal-age candidate never displaces the current best,
  // which gives the lower-index tie-break for free.
  always_comb begin
    best_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      if (elig[i] && (!found ||
          age_older(ages[i], ages[best_idx], IQ_IDX_W'(i), best_idx))) begin
        best_idx = IQ_IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign pick_idx    = best_idx;
  assign pick_valid  = found;
  assign pick_onehot = found ? (CIQ_DEPTH'(1) << best_idx) : '0;

endmodule

// File: rtl/issue_select.sv
// Age-ordered select arbiter: cascaded oldest picks mapped onto ready issue
// ports, registered grants, and a one-cycle grant history against re-grants.
module issue_select
  import issue_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CIQ_DEPTH-1:0]           req,
  input  logic [CIQ_DEPTH-1:0][AGE-1:0]  entry_age,
  input  logic [ISSUE_NUM-1:0]           port_ready,
  input  logic                           flush,
  output logic [ISSUE_NUM-1:0][IQ_IDX_W-1:0] arbit_addr,
  output logic [ISSUE_NUM-1:0]           arbit_grant
);

  logic [CIQ_DEPTH-1:0]                 recent_reg;
  logic [CIQ_DEPTH-1:0]                 recent_next;
  logic [ISSUE_NUM-1:0]                 grant_reg;
  logic [ISSUE_NUM-1:0]                 grant_next;
  logic [ISSUE_NUM-1:0][IQ_IDX_W-1:0]   addr_reg;
  logic [ISSUE_NUM-1:0][IQ_IDX_W-1:0]   addr_next;

  logic [CIQ_DEPTH-1:0]                 elig;
  logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0]  remaining;
  logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0]  pick_onehot;
  logic [ISSUE_NUM-1:0][IQ_IDX_W-1:0]   pick_idx;
  logic [ISSUE_NUM-1:0]                 pick_valid;

  assign elig         = req & ~recent_reg & {CIQ_DEPTH{~flush}};
  assign remaining[0] = elig;

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_NUM; gi++) begin : g_stage
      oldest_pick u_pick (
        .elig        (remaining[gi]),
        .ages        (entry_age),
        .pick_onehot (pick_onehot[gi]),
        .pick_idx    (pick_idx[gi]),
        .pick_valid  (pick_valid[gi])
      );
      if (gi < ISSUE_NUM - 1) begin : g_chain
        assign remaining[gi+1] = remaining[gi] & ~pick_onehot[gi];
      end
    end
  endgenerate

  // The n-th ready port (ascending) takes the n-th pick; picks beyond the
  // ready-port count are dropped and leave no trace in recent.
  always_comb begin
    logic [1:0] slot;
    grant_next  = '0;
    addr_next   = '0;
    recent_next = '0;
    slot        = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      if (port_ready[k]) begin
        if (pick_valid[slot]) begin
          grant_next[k] = 1'b1;
          addr_next[k]  = pick_idx[slot];
          recent_next   = recent_next | pick_onehot[slot];
        end
        slot = slot + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg  <= '0;
      addr_reg   <= '0;
      recent_reg <= '0;
    end else begin
      grant_reg  <= grant_next;
      addr_reg   <= addr_next;
      recent_reg <= recent_next;
    end
  end

  assign arbit_grant = grant_reg;
  assign arbit_addr  = addr_reg;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: each step drives inputs, advances one
// clock and checks the registered grant/address against hand-computed values.
module tb_issue_select;
  import issue_pkg::*;

  logic                               clk;
  logic                               rst;
  logic [CIQ_DEPTH-1:0]               req;
  logic [CIQ_DEPTH-1:0][AGE-1:0]      entry_age;
  logic [ISSUE_NUM-1:0]               port_ready;
  logic                               flush;
  logic [ISSUE_NUM-1:0][IQ_IDX_W-1:0] arbit_addr;
  logic [ISSUE_NUM-1:0]               arbit_grant;

  int tests_run = 0;
  int tests_failed = 0;

  issue_select dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .entry_age   (entry_age),
    .port_ready  (port_ready),
    .flush       (flush),
    .arbit_addr  (arbit_addr),
    .arbit_grant (arbit_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] exp_grant, input logic [15:0] exp_addr);
    @(posedge clk);
    #1;
    $display("[TB] %s grant=%b addr=%h", tag, arbit_grant, arbit_addr);
    check({tag, "_grant"}, 32'(arbit_grant), 32'(exp_grant));
    check({tag, "_addr"}, 32'(arbit_addr), 32'(exp_addr));
  endtask

  task automatic set_ages_zero();
    for (int i = 0; i < CIQ_DEPTH; i++) entry_age[i] = '0;
  endtask

  initial begin
    rst = 1'b1; req = 16'hFFFF; port_ready = 4'hF; flush = 1'b0;
    set_ages_zero();

    // Reset with all entries requesting
    step("rst0", 4'h0, 16'h0000);
    step("rst1", 4'h0, 16'h0000);

    // Equal ages: index tie-break, then recent masks 0..3 for one cycle
    rst = 1'b0;
    step("full0", 4'hF, 16'h3210);
    step("full1", 4'hF, 16'h7654);
    step("full2", 4'hF, 16'h3210);

    req = 16'h0000;
    step("idle0", 4'h0, 16'h0000);
    step("idle1", 4'h0, 16'h0000);

    // Wrap-around age order: 30,31 older than 1,2
    req = 16'h1288;
    entry_age[3] = 5'd30; entry_age[7] = 5'd31; entry_age[9] = 5'd1; entry_age[12] = 5'd2;
    step("wrap", 4'hF, 16'hC973);
    req = 16'h0000; set_ages_zero();
    step("idle2", 4'h0, 16'h0000);
    step("idle3", 4'h0, 16'h0000);

    // Port masking: only ports 1 and 3 ready
    req = 16'h003F;
    for (int i = 0; i < 6; i++) entry_age[i] = 5'(i);
    port_ready = 4'b1010;
    step("mask0", 4'b1010, 16'h1000);
    port_ready = 4'hF;
    step("mask1", 4'hF, 16'h5432);
    step("mask2", 4'b0011, 16'h0010);
    req = 16'h0000; set_ages_zero();
    step("idle4", 4'h0, 16'h0000);
    step("idle5", 4'h0, 16'h0000);

    // No ready ports: entry waits without penalty
    req = 16'h0001; port_ready = 4'h0;
    step("noport", 4'h0, 16'h0000);
    port_ready = 4'hF;
    step("noport_after", 4'h1, 16'h0000);
    req = 16'h0000;
    step("idle6", 4'h0, 16'h0000);
    step("idle7", 4'h0, 16'h0000);

    // Double-issue guard on a single entry
    req = 16'h0020;
    step("dbl0", 4'h1, 16'h0005);
    step("dbl1", 4'h0, 16'h0000);
    step("dbl2", 4'h1, 16'h0005);
    req = 16'h0000;
    step("idle8", 4'h0, 16'h0000);
    step("idle9", 4'h0, 16'h0000);

    // Flush cancels selection and clears recent
    req = 16'h000F;
    step("pre_flush", 4'hF, 16'h3210);
    flush = 1'b1;
    step("flush", 4'h0, 16'h0000);
    flush = 1'b0;
    step("post_flush", 4'hF, 16'h3210);

    // Mid-operation reset together with flush
    req = 16'hFFFF;
    step("pre_rst", 4'hF, 16'h7654);
    rst = 1'b1; flush = 1'b1;
    step("mid_rst", 4'h0, 16'h0000);
    rst = 1'b0; flush = 1'b0;
    step("post_rst", 4'hF, 16'h3210);
    step("post_rst1", 4'hF, 16'h7654);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
